// File: rtl/router_fsm_np.sv
// Control FSM for a 1xN packet router: header decode, payload load,
// FIFO-full stall, parity load/check, plus drop of unroutable packets
// and an optional timeout while waiting for the destination FIFO to drain.
module router_fsm_np #(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 packet_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    dest_addr,
  output logic                 wait_timeout,
  output logic [3:0]           present_state
);

  localparam int unsigned         NUM_ADDR   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]     PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0]    WAIT_LAST  = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
  localparam logic                TIMEOUT_EN = (WAIT_TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_DECODE_ADDRESS     = 4'd1,
    S_WAIT_TILL_EMPTY    = 4'd2,
    S_LOAD_FIRST_DATA    = 4'd3,
    S_LOAD_DATA          = 4'd4,
    S_LOAD_PARITY        = 4'd5,
    S_FIFO_FULL_STATE    = 4'd6,
    S_LOAD_AFTER_FULL    = 4'd7,
    S_CHECK_PARITY_ERROR = 4'd8,
    S_DROP_PACKET        = 4'd9
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  dest_addr_q, dest_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_tail_q, drop_tail_d;
  logic               wait_timeout_q, wait_timeout_d;

  // Per-port flags widened to the full address space so any address indexes safely.
  logic [NUM_ADDR-1:0] empty_all;
  logic [NUM_ADDR-1:0] srst_all;
  logic                hdr_in_range;
  logic                srst_hit;

  // Address-space views of the per-port inputs and the soft-reset qualifier.
  always_comb begin
    empty_all    = NUM_ADDR'(fifo_empty);
    srst_all     = NUM_ADDR'(soft_reset);
    hdr_in_range = ((ADDR_W+1)'(data_in) < PORT_LIMIT);
    srst_hit     = srst_all[dest_addr_q] &&
                   (state_q != S_DECODE_ADDRESS) && (state_q != S_DROP_PACKET);
  end

  // Next-state, destination latch, wait counter and timeout pulse.
  always_comb begin
    state_d        = state_q;
    dest_addr_d    = dest_addr_q;
    cnt_d          = '0;
    drop_tail_d    = 1'b0;
    wait_timeout_d = 1'b0;

    if ((state_q == S_DECODE_ADDRESS) && packet_valid) begin
      dest_addr_d = data_in;
    end

    if (state_q == S_WAIT_TILL_EMPTY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_DECODE_ADDRESS: begin
        if (packet_valid) begin
          if (!hdr_in_range)               state_d = S_DROP_PACKET;
          else if (empty_all[data_in])     state_d = S_LOAD_FIRST_DATA;
          else                             state_d = S_WAIT_TILL_EMPTY;
        end
      end
      S_WAIT_TILL_EMPTY: begin
        if (empty_all[dest_addr_q]) begin
          state_d = S_LOAD_FIRST_DATA;
        end else if (TIMEOUT_EN && (cnt_q == WAIT_LAST)) begin
          state_d        = S_DROP_PACKET;
          wait_timeout_d = 1'b1;
        end
      end
      S_LOAD_FIRST_DATA: state_d = S_LOAD_DATA;
      S_LOAD_DATA: begin
        if (fifo_full)          state_d = S_FIFO_FULL_STATE;
        else if (!packet_valid) state_d = S_LOAD_PARITY;
      end
      S_FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = S_LOAD_AFTER_FULL;
      end
      S_LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = S_DECODE_ADDRESS;
        else if (low_packet_valid) state_d = S_LOAD_PARITY;
        else                       state_d = S_LOAD_DATA;
      end
      S_LOAD_PARITY: state_d = S_CHECK_PARITY_ERROR;
      S_CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
      end
      S_DROP_PACKET: begin
        // Swallow the parity byte (first low cycle) before returning to decode.
        if (drop_tail_q)        state_d     = S_DECODE_ADDRESS;
        else if (!packet_valid) drop_tail_d = 1'b1;
      end
      default: state_d = S_DECODE_ADDRESS;
    endcase

    // Read-side soft reset of the selected port aborts the packet.
    if (srst_hit) begin
      state_d        = S_DECODE_ADDRESS;
      drop_tail_d    = 1'b0;
      wait_timeout_d = 1'b0;
    end
  end

  // State and control registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_DECODE_ADDRESS;
      dest_addr_q    <= '0;
      cnt_q          <= '0;
      drop_tail_q    <= 1'b0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dest_addr_q    <= dest_addr_d;
      cnt_q          <= cnt_d;
      drop_tail_q    <= drop_tail_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  // State decodes for the datapath.
  always_comb begin
    detect_add    = (state_q == S_DECODE_ADDRESS);
    lfd_state     = (state_q == S_LOAD_FIRST_DATA);
    ld_state      = (state_q == S_LOAD_DATA);
    full_state    = (state_q == S_FIFO_FULL_STATE);
    laf_state     = (state_q == S_LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == S_CHECK_PARITY_ERROR);
    drop_state    = (state_q == S_DROP_PACKET);
    write_enb_reg = (state_q == S_LOAD_DATA) || (state_q == S_LOAD_AFTER_FULL) ||
                    (state_q == S_LOAD_PARITY);
    busy          = !((state_q == S_DECODE_ADDRESS) || (state_q == S_LOAD_DATA) ||
                      (state_q == S_DROP_PACKET));
    dest_addr     = dest_addr_q;
    wait_timeout  = wait_timeout_q;
    present_state = state_q;
  end

endmodule

// File: tb/tb_router_fsm_np.sv
// Bench for router_fsm_np: directed packet scenarios plus random traffic,
// all checked every cycle against a behavioural packet-flow model.
module tb_router_fsm_np;

  localparam int NP = 3;
  localparam int TO = 8;

  // Symbolic state codes of the router control sequence.
  localparam int DEC = 1, WAIT = 2, LFD = 3, LD = 4, LP = 5, FULL = 6, LAF = 7, CPE = 8, DROP = 9;

  logic       clk = 1'b0;
  logic       resetn, packet_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic       drop_state, write_enb_reg, busy, wait_timeout;
  logic [1:0] dest_addr;
  logic [3:0] present_state;

  int n_checks = 0;
  int n_errors = 0;

  router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(2), .WAIT_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .drop_state(drop_state), .write_enb_reg(write_enb_reg), .busy(busy),
    .dest_addr(dest_addr), .wait_timeout(wait_timeout), .present_state(present_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = DEC;
  int m_dest  = 0;
  int m_wait  = 0;   // WAIT cycles already completed for the current packet
  bit m_low   = 0;   // drop has already seen the parity (first low) cycle
  bit m_to    = 0;

  task automatic model_step(input bit rn, input bit pv, input int din, input bit full,
                            input bit [2:0] emp, input bit [2:0] srst, input bit pd,
                            input bit lpv);
    int nxt;
    bit fire;
    if (!rn) begin
      m_state = DEC; m_dest = 0; m_wait = 0; m_low = 0; m_to = 0;
      return;
    end
    nxt  = m_state;
    fire = 0;
    case (m_state)
      DEC:  if (pv) nxt = (din >= NP) ? DROP : (emp[din] ? LFD : WAIT);
      WAIT: if (emp[m_dest]) nxt = LFD;
            else if (TO != 0 && m_wait + 1 == TO) begin nxt = DROP; fire = 1; end
      LFD:  nxt = LD;
      LD:   nxt = full ? FULL : (pv ? LD : LP);
      LP:   nxt = CPE;
      FULL: nxt = full ? FULL : LAF;
      LAF:  nxt = pd ? DEC : (lpv ? LP : LD);
      CPE:  nxt = full ? FULL : DEC;
      DROP: if (m_low) nxt = DEC;
      default: nxt = DEC;
    endcase
    if (m_state != DEC && m_state != DROP && m_dest < NP && srst[m_dest]) begin
      nxt = DEC; fire = 0;
    end
    m_low  = (m_state == DROP) && (nxt == DROP) && !pv;
    m_wait = (m_state == WAIT && nxt == WAIT) ? m_wait + 1 : 0;
    if (m_state == DEC && pv) m_dest = din;
    m_to    = fire;
    m_state = nxt;
  endtask

  // Advance the model on each edge, then compare the DUT just after it.
  always @(posedge clk) begin
    logic [8:0] exp_flags, got_flags;
    model_step(resetn, packet_valid, int'(data_in), fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid);
    #1;
    exp_flags = {m_state == DEC, m_state == LFD, m_state == LD, m_state == FULL,
                 m_state == LAF, m_state == CPE, m_state == DROP,
                 (m_state == LD || m_state == LAF || m_state == LP),
                 !(m_state == DEC || m_state == LD || m_state == DROP)};
    got_flags = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                 drop_state, write_enb_reg, busy};
    chk("model_state", int'(present_state), m_state);
    chk("model_decodes", int'(got_flags), int'(exp_flags));
    chk("model_dest", int'(dest_addr), m_dest);
    chk("model_timeout", int'(wait_timeout), int'(m_to));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step_chk(input string nm, input int exp_st);
    tick();
    chk(nm, int'(present_state), exp_st);
  endtask

  task automatic idle_inputs();
    packet_valid = 0; data_in = 0; fifo_full = 0; soft_reset = 0;
    parity_done = 0; low_packet_valid = 0;
  endtask

  initial begin
    int acc, acc2, acc3;
    resetn = 0; fifo_empty = 3'b111;
    idle_inputs();
    tick(); tick();
    chk("rst_state", int'(present_state), DEC);
    chk("rst_detect", int'(detect_add), 1);
    chk("rst_dest", int'(dest_addr), 0);
    chk("rst_wer", int'(write_enb_reg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(wait_timeout), 0);
    resetn = 1;

    // Normal packet to port 1 with 4 payload bytes.
    packet_valid = 1; data_in = 2'd1;
    step_chk("t1_lfd", LFD);
    chk("t1_dest", int'(dest_addr), 1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin step_chk("t1_ld", LD); acc += int'(write_enb_reg); end
    packet_valid = 0;
    step_chk("t1_lp", LP);  acc += int'(write_enb_reg);
    step_chk("t1_cpe", CPE); acc += int'(write_enb_reg);
    step_chk("t1_dec", DEC); acc += int'(write_enb_reg);
    chk("t1_wer_cycles", acc, 5);

    // Unroutable address is dropped without writes and with busy low.
    packet_valid = 1; data_in = 2'd3;
    acc = 0;
    step_chk("t2_drop", DROP); acc += int'(busy) + int'(write_enb_reg);
    for (int i = 0; i < 2; i++) begin step_chk("t2_drop", DROP); acc += int'(busy) + int'(write_enb_reg); end
    packet_valid = 0;
    step_chk("t2_tail", DROP); acc += int'(busy) + int'(write_enb_reg);
    step_chk("t2_dec", DEC);
    chk("t2_busy_wer", acc, 0);

    // Destination never drains: 8 WAIT cycles then drop with one timeout pulse.
    fifo_empty = 3'b011; packet_valid = 1; data_in = 2'd2;
    acc = 0; acc2 = 0; acc3 = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      acc  += int'(present_state == 4'(WAIT));
      acc2 += int'(present_state == 4'(WAIT) && busy);
      acc3 += int'(wait_timeout);
      if (i == 8) begin
        chk("t3_drop_after_wait", int'(present_state), DROP);
        chk("t3_pulse_cycle", int'(wait_timeout), 1);
      end
    end
    chk("t3_wait_cycles", acc, 8);
    chk("t3_busy_in_wait", acc2, 8);
    chk("t3_timeout_pulses", acc3, 1);
    packet_valid = 0;
    step_chk("t3_tail", DROP);
    step_chk("t3_dec", DEC);

    // Destination drains on the 8th WAIT cycle: empty wins over timeout.
    packet_valid = 1; data_in = 2'd2;
    acc3 = 0;
    step_chk("t3b_wait", WAIT);
    for (int i = 0; i < 7; i++) begin step_chk("t3b_wait", WAIT); acc3 += int'(wait_timeout); end
    fifo_empty = 3'b111;
    step_chk("t3b_lfd", LFD); acc3 += int'(wait_timeout);
    packet_valid = 0;
    step_chk("t3b_ld", LD); acc3 += int'(wait_timeout);
    chk("t3b_no_timeout", acc3, 0);
    step_chk("t3b_lp", LP);
    step_chk("t3b_cpe", CPE);
    step_chk("t3b_dec", DEC);

    // FIFO full for 3 cycles starting on the second LOAD_DATA cycle.
    packet_valid = 1; data_in = 2'd0;
    step_chk("t4_lfd", LFD);
    step_chk("t4_ld1", LD);
    step_chk("t4_ld2", LD);
    fifo_full = 1; acc = 0;
    for (int i = 0; i < 3; i++) begin step_chk("t4_full", FULL); acc += int'(write_enb_reg); end
    chk("t4_wer_in_full", acc, 0);
    fifo_full = 0;
    step_chk("t4_laf", LAF);
    step_chk("t4_ld", LD);
    packet_valid = 0;
    step_chk("t4_lp", LP);
    step_chk("t4_cpe", CPE);
    step_chk("t4_dec", DEC);

    // Soft reset: only the bit of the selected port aborts.
    packet_valid = 1; data_in = 2'd0;
    step_chk("t5_lfd", LFD);
    step_chk("t5_ld", LD);
    soft_reset = 3'b010;
    step_chk("t5_other_port", LD);
    soft_reset = 3'b001;
    step_chk("t5_own_port", DEC);
    soft_reset = 3'b000; packet_valid = 0;
    step_chk("t5_idle", DEC);

    // Reset while stalled on a full FIFO.
    packet_valid = 1; data_in = 2'd1;
    step_chk("t6_lfd", LFD);
    step_chk("t6_ld", LD);
    fifo_full = 1;
    step_chk("t6_full", FULL);
    resetn = 0;
    step_chk("t6_rst_state", DEC);
    chk("t6_rst_detect", int'(detect_add), 1);
    chk("t6_rst_dest", int'(dest_addr), 0);
    chk("t6_rst_others", int'({lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                               drop_state, write_enb_reg, busy, wait_timeout}), 0);
    resetn = 1; fifo_full = 0; packet_valid = 0;
    step_chk("t6_after", DEC);
    chk("t6_no_write", int'(write_enb_reg), 0);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      resetn           = ($urandom_range(0, 99) != 0);
      packet_valid     = ($urandom_range(0, 9) < 8);
      data_in          = 2'($urandom_range(0, 3));
      fifo_full        = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) fifo_empty = 3'($urandom);
      soft_reset       = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
      parity_done      = ($urandom_range(0, 4) == 0);
      low_packet_valid = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_inputs();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Generalised packet-router control FSM for a 1xN router with a parametrised port count and address width.
- Sits between the input register/parity block and the N output FIFOs. It sequences header decode, payload load, FIFO-full stall, parity load and parity check, exactly as the 3-port controller did.
- Adds three behaviours:
  - Packets addressed to a port that does not exist are dropped.
  - A configurable timeout on waiting for the destination FIFO to drain; on expiry the packet is dropped.
  - A registered timeout flag.

Parameters:
NUM_PORTS, 3, number of output ports/FIFOs; legal range 1..2**ADDR_W
ADDR_W, 2, width of the header destination field
WAIT_TIMEOUT, 0, cycles allowed in WAIT_TILL_EMPTY before dropping; 0 disables the timeout
CNT_W, 16, width of the wait counter; WAIT_TIMEOUT must be < 2**CNT_W

Ports:
clk  in  1  clock
resetn  in  1  reset
packet_valid  in  1  source packet valid; high from header through last payload byte
data_in  in  ADDR_W  destination field of the header byte
fifo_full  in  1  full flag of the currently selected FIFO
fifo_empty  in  NUM_PORTS  per-port FIFO empty flags
soft_reset  in  NUM_PORTS  per-port soft reset (read-side timeout)
parity_done  in  1  parity byte has been written
low_packet_valid  in  1  packet_valid fell while in FIFO_FULL_STATE
detect_add  out  1  state == DECODE_ADDRESS
lfd_state  out  1  state == LOAD_FIRST_DATA
ld_state  out  1  state == LOAD_DATA
full_state  out  1  state == FIFO_FULL_STATE
laf_state  out  1  state == LOAD_AFTER_FULL
rst_int_reg  out  1  state == CHECK_PARITY_ERROR
drop_state  out  1  state == DROP_PACKET; downstream must not write
write_enb_reg  out  1  state in {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY}
busy  out  1  state not in {DECODE_ADDRESS, LOAD_DATA, DROP_PACKET}
dest_addr  out  ADDR_W  latched destination
wait_timeout  out  1  registered one-cycle pulse on timeout
present_state  out  4  current state, for debug

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. Reset values:
  - present_state = DECODE_ADDRESS, so detect_add=1 and every other state decode is 0.
  - dest_addr=0, wait counter=0, wait_timeout=0.
  - A reset mid-packet abandons the packet; no write_enb_reg follows.
- State encodings:
  - DECODE_ADDRESS=1, WAIT_TILL_EMPTY=2, LOAD_FIRST_DATA=3, LOAD_DATA=4, LOAD_PARITY=5, FIFO_FULL_STATE=6, LOAD_AFTER_FULL=7, CHECK_PARITY_ERROR=8, DROP_PACKET=9.
  - Any other value goes to DECODE_ADDRESS.
- dest_addr loads data_in when detect_add && packet_valid. It holds otherwise.
- All outputs except wait_timeout are decoded combinationally from present_state.
- DECODE_ADDRESS, when packet_valid:
  - data_in >= NUM_PORTS -> DROP_PACKET.
  - else fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - else -> WAIT_TILL_EMPTY.
  - When !packet_valid, stay.
- WAIT_TILL_EMPTY:
  - The counter clears on entry and increments each cycle in this state.
  - fifo_empty[dest_addr] -> LOAD_FIRST_DATA. Empty has priority over timeout in the same cycle.
  - else if WAIT_TIMEOUT!=0 && counter==WAIT_TIMEOUT-1 -> DROP_PACKET, and wait_timeout=1 on the next cycle only.
  - else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - else !packet_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_packet_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- DROP_PACKET:
  - Stays while packet_valid. On the first cycle packet_valid=0 (the parity byte), stays that cycle, then -> DECODE_ADDRESS.
  - write_enb_reg=0 throughout. busy=0 so the source drains.
- Soft reset:
  - soft_reset[dest_addr]=1 forces present_state to DECODE_ADDRESS next cycle. This overrides every other transition.
  - Honoured only in states other than DECODE_ADDRESS and DROP_PACKET.
  - soft_reset bits for other ports are ignored.
- NUM_PORTS == 2**ADDR_W: the out-of-range drop path is unreachable. This is legal.

Test Plan:
- NUM_PORTS=3, fifo_empty=3'b111, packet_valid for header addr 1 plus 4 payload cycles, then low. Required states: DECODE -> LFD -> LD x4 -> LOAD_PARITY -> CHECK_PARITY -> DECODE; write_enb_reg high 5 cycles; dest_addr=1.
- Header addr 3 with NUM_PORTS=3. Required: DROP_PACKET next cycle; busy=0 and write_enb_reg=0 until one cycle after packet_valid falls; then DECODE.
- WAIT_TIMEOUT=8, addr 2, fifo_empty[2]=0 held. Required: 8 cycles in WAIT with busy=1, then DROP_PACKET, wait_timeout high exactly 1 cycle. Repeat with fifo_empty[2] rising on the 8th WAIT cycle -> LOAD_FIRST_DATA, no timeout.
- fifo_full asserted on LD cycle 2 for 3 cycles, low_packet_valid=0. Required: FULL x3 -> LAF -> LD; write_enb_reg low during FULL.
- dest_addr=0, in LOAD_DATA: pulse soft_reset=3'b010 (no effect), then 3'b001. Required: only the second pulse returns to DECODE, the following cycle.
- resetn low for 1 cycle while in FIFO_FULL_STATE. Required: DECODE, detect_add=1, all other outputs 0, dest_addr=0.
